// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN  = 16;
    localparam int unsigned OPC_W = 4;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [OPC_W-1:0] opcode_t;

    localparam word_t   FETCH_NOP_INSTR   = 16'h0000;
    localparam opcode_t FETCH_HALT_OPCODE = 4'hF;
    localparam word_t   FETCH_PC_INC      = 16'd2;
    localparam word_t   FETCH_RESET_PC    = 16'h0000;

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        VALID,
        DRAIN,
        HALTED
    } fetch_state_e;

    // Payload handed to the F/D register: instruction, its PC and the sequential successor.
    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t pc_next;
    } fd_payload_t;

    function automatic logic is_halt(input word_t instr, input opcode_t halt_opc);
        return instr[XLEN-1 -: OPC_W] == halt_opc;
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Capture register for a fetched instruction and its PC / PC+inc.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture d on the rising edge
//   d, q       : payload in / held payload out
module fetch_hold_reg
    import fetch_pkg::*;
#(
    parameter word_t RESET_INSTR = FETCH_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  fd_payload_t d,
    output fd_payload_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.instr   <= RESET_INSTR;
            q.pc      <= '0;
            q.pc_next <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to a
// variable-latency instruction memory and feeds the F/D pipeline register.
//   clk, rst        : clock, asynchronous active-low reset
//   stall           : hold F/D, do not advance
//   redirect        : taken branch resolved in decode, target on redirect_pc
//   imem_req/addr   : one-cycle request strobe and address (current PC)
//   imem_rdy/data   : memory response
//   fd_wen          : F/D write enable
//   instruction_out, oldPC_out, newPC_out, halt_out : F/D payload
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t   RESET_PC    = FETCH_RESET_PC,
    parameter word_t   PC_INC      = FETCH_PC_INC,
    parameter word_t   NOP_INSTR   = FETCH_NOP_INSTR,
    parameter opcode_t HALT_OPCODE = FETCH_HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic        fd_wen,
    output logic [15:0] instruction_out,
    output logic [15:0] oldPC_out,
    output logic [15:0] newPC_out,
    output logic        halt_out
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    word_t        pc;
    word_t        pc_nxt;
    word_t        pc_inc;
    fd_payload_t  held;
    fd_payload_t  held_d;
    logic         held_load;
    logic         held_is_halt;
    logic         redirect_act;

    assign pc_inc       = XLEN'(pc + PC_INC);
    assign held_is_halt = is_halt(held.instr, HALT_OPCODE);
    // Redirect is ignored while reset is asserted so no write leaks out.
    assign redirect_act = rst && redirect;

    // Captured instruction plus the PC pair that travels with it.
    fetch_hold_reg #(
        .RESET_INSTR (NOP_INSTR)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst),
        .load  (held_load),
        .d     (held_d),
        .q     (held)
    );

    // Next-state, PC update and capture control; redirect beats stall and imem_rdy.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        held_load      = 1'b0;
        held_d.instr   = imem_data;
        held_d.pc      = pc;
        held_d.pc_next = pc_inc;

        if (redirect) begin
            pc_nxt = redirect_pc;
            // A request is still in flight in these cases; its response must be drained.
            if ((state == FETCH) ||
                ((state == WAIT || state == DRAIN) && !imem_rdy)) begin
                state_nxt = DRAIN;
            end else begin
                state_nxt = FETCH;
            end
        end else begin
            case (state)
                FETCH: state_nxt = WAIT;
                WAIT: begin
                    if (imem_rdy) begin
                        held_load = 1'b1;
                        state_nxt = VALID;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        if (held_is_halt) begin
                            state_nxt = HALTED;
                        end else begin
                            pc_nxt    = pc_inc;
                            state_nxt = FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_rdy) begin
                        state_nxt = FETCH;
                    end
                end
                HALTED:  state_nxt = HALTED;
                default: state_nxt = FETCH;
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Request strobe is decoded from state; gated so it stays low during reset.
    assign imem_req  = rst && (state == FETCH);
    assign imem_addr = pc;

    // F/D interface: a redirect forces a NOP bubble into F/D in the same cycle.
    assign fd_wen          = redirect_act || (rst && (state == VALID) && !stall);
    assign instruction_out = redirect_act ? NOP_INSTR : held.instr;
    assign oldPC_out       = held.pc;
    assign newPC_out       = held.pc_next;
    assign halt_out        = !redirect_act && held_is_halt &&
                             ((state == VALID) || (state == HALTED));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a behavioural variable-latency memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        fd_wen;
    logic [15:0] instruction_out;
    logic [15:0] oldPC_out;
    logic [15:0] newPC_out;
    logic        halt_out;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] old_pc;
        logic [15:0] new_pc;
        logic        halt;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_req[$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdy        (imem_rdy),
        .imem_data       (imem_data),
        .fd_wen          (fd_wen),
        .instruction_out (instruction_out),
        .oldPC_out       (oldPC_out),
        .newPC_out       (newPC_out),
        .halt_out        (halt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0002: return 16'hF000;
            16'h0010: return 16'hF000;
            16'h0022: return 16'hF000;
            16'h0040: return 16'hF000;
            default:  return {4'h1, a[11:0]};
        endcase
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [15:0] i, input logic [15:0] o,
                           input logic [15:0] n, input logic h);
        wr_t e;
        e.instr = i; e.old_pc = o; e.new_pc = n; e.halt = h;
        exp_wr.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (2) cyc();
    endtask

    // Wait for all expected traffic, then idle a few cycles so stray traffic is caught.
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_req.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        checks++;
        if (exp_wr.size() != 0 || exp_req.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d writes and %0d requests still pending",
                     exp_wr.size(), exp_req.size());
            exp_wr.delete();
            exp_req.delete();
        end
        repeat (3) cyc();
    endtask

    // Memory: response lat cycles after the request cycle; cleared by reset.
    initial begin : mem_model
        logic        req_s;
        logic [15:0] addr_s;
        logic [15:0] paddr;
        logic        pending;
        int          cnt;
        pending = 1'b0;
        paddr   = 16'h0000;
        cnt     = 0;
        forever begin
            @(negedge clk);
            req_s  = imem_req;
            addr_s = imem_addr;
            @(posedge clk);
            #1;
            imem_rdy = 1'b0;
            if (!rst) begin
                pending = 1'b0;
            end else begin
                if (req_s) begin
                    pending = 1'b1;
                    cnt     = lat;
                    paddr   = addr_s;
                end
                if (pending) begin
                    cnt--;
                    if (cnt <= 0) begin
                        imem_rdy  = 1'b1;
                        imem_data = mem_word(paddr);
                        pending   = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every F/D write and every memory request.
    initial begin : monitor
        wr_t         e;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            if (fd_wen === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fd_write: unexpected write instr=%h old=%h new=%h halt=%b",
                             instruction_out, oldPC_out, newPC_out, halt_out);
                end else begin
                    e = exp_wr.pop_front();
                    check16("fd_instr", instruction_out, e.instr);
                    check16("fd_oldpc", oldPC_out, e.old_pc);
                    check16("fd_newpc", newPC_out, e.new_pc);
                    check1("fd_halt", halt_out, e.halt);
                end
            end
            if (imem_req === 1'b1) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL imem_req: unexpected request addr=%h", imem_addr);
                end else begin
                    a = exp_req.pop_front();
                    check16("imem_addr", imem_addr, a);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit found;

        // Reset values
        rst = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        check1("rst_req", imem_req, 1'b0);
        check16("rst_addr", imem_addr, 16'h0000);
        check1("rst_wen", fd_wen, 1'b0);
        check16("rst_instr", instruction_out, 16'h0000);
        check16("rst_oldpc", oldPC_out, 16'h0000);
        check16("rst_newpc", newPC_out, 16'h0000);
        check1("rst_halt", halt_out, 1'b0);
        cyc();

        // 1: basic fetch, latency 1
        exp_req.push_back(16'h0000); push_wr(16'h1234, 16'h0000, 16'h0002, 1'b0);
        exp_req.push_back(16'h0002); push_wr(16'hF000, 16'h0002, 16'h0004, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check1("t1_req_c1", imem_req, 1'b1);
        check16("t1_addr_c1", imem_addr, 16'h0000);
        cyc();
        cyc();
        @(negedge clk);
        check1("t1_wen_c3", fd_wen, 1'b1);
        wait_idle(40);

        // 2: stall for 4 cycles in VALID
        do_reset();
        exp_req.push_back(16'h0000); push_wr(16'h1234, 16'h0000, 16'h0002, 1'b0);
        exp_req.push_back(16'h0002); push_wr(16'hF000, 16'h0002, 16'h0004, 1'b1);
        rst = 1'b1;
        cyc();
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("t2_stall_wen", fd_wen, 1'b0);
            check1("t2_stall_req", imem_req, 1'b0);
            check16("t2_stall_instr", instruction_out, 16'h1234);
            check16("t2_stall_old", oldPC_out, 16'h0000);
            check16("t2_stall_new", newPC_out, 16'h0002);
            cyc();
        end
        stall = 1'b0;
        @(negedge clk);
        check1("t2_release_wen", fd_wen, 1'b1);
        wait_idle(40);

        // 3: redirect in WAIT, latency 3
        do_reset();
        lat = 3;
        exp_req.push_back(16'h0000); push_wr(16'h0000, 16'h0000, 16'h0000, 1'b0);
        exp_req.push_back(16'h0040); push_wr(16'hF000, 16'h0040, 16'h0042, 1'b1);
        rst = 1'b1;
        cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        check1("t3_bubble_wen", fd_wen, 1'b1);
        check16("t3_bubble_instr", instruction_out, 16'h0000);
        cyc();
        redirect = 1'b0;
        wait_idle(40);
        lat = 1;

        // 4: redirect in FETCH to a HLT at 0x0010, then stay halted
        do_reset();
        exp_req.push_back(16'h0000); push_wr(16'h0000, 16'h0000, 16'h0000, 1'b0);
        exp_req.push_back(16'h0010); push_wr(16'hF000, 16'h0010, 16'h0012, 1'b1);
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        @(negedge clk);
        check1("t4_req_with_redirect", imem_req, 1'b1);
        cyc();
        redirect = 1'b0;
        wait_idle(40);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check1("t4_halted_req", imem_req, 1'b0);
            check1("t4_halted_wen", fd_wen, 1'b0);
            check1("t4_halted_halt", halt_out, 1'b1);
            check16("t4_halted_pc", imem_addr, 16'h0010);
            cyc();
        end

        // 5: redirect out of HALTED to 0x0020
        push_wr(16'h0000, 16'h0010, 16'h0012, 1'b0);
        exp_req.push_back(16'h0020); push_wr(16'h1020, 16'h0020, 16'h0022, 1'b0);
        exp_req.push_back(16'h0022); push_wr(16'hF000, 16'h0022, 16'h0024, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        @(negedge clk);
        check1("t5_bubble_halt", halt_out, 1'b0);
        check1("t5_bubble_wen", fd_wen, 1'b1);
        cyc();
        redirect = 1'b0;
        wait_idle(40);

        // 6: PC wrap at 0xFFFE, then reset in the middle of WAIT
        push_wr(16'h0000, 16'h0022, 16'h0024, 1'b0);
        exp_req.push_back(16'hFFFE); push_wr(16'h1FFE, 16'hFFFE, 16'h0000, 1'b0);
        exp_req.push_back(16'h0000); push_wr(16'h1234, 16'h0000, 16'h0002, 1'b0);
        exp_req.push_back(16'h0002);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        cyc();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_addr === 16'h0002) found = 1'b1;
        end
        check1("t6_reached_fetch2", found, 1'b1);
        cyc();
        rst = 1'b0;
        #1;
        check1("t6_rst_req", imem_req, 1'b0);
        check16("t6_rst_pc", imem_addr, 16'h0000);
        check1("t6_rst_wen", fd_wen, 1'b0);
        check16("t6_rst_instr", instruction_out, 16'h0000);
        check16("t6_rst_old", oldPC_out, 16'h0000);
        check16("t6_rst_new", newPC_out, 16'h0000);
        check1("t6_rst_halt", halt_out, 1'b0);
        check16("t6_pending_writes", 16'(exp_wr.size()), 16'd0);
        check16("t6_pending_reqs", 16'(exp_req.size()), 16'd0);
        repeat (2) cyc();
        exp_req.push_back(16'h0000); push_wr(16'h1234, 16'h0000, 16'h0002, 1'b0);
        exp_req.push_back(16'h0002); push_wr(16'hF000, 16'h0002, 16'h0004, 1'b1);
        rst = 1'b1;
        wait_idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
